// File: rtl/cacop_sched.sv
// rtl/cacop_sched.sv - CACOP cache-maintenance sequencer between WB and the icache/dcache controllers
//
// Accepts one level-held CACOP request from WB, decodes its target cache and op type,
// drains the dcache when needed, issues the op through a valid/ready handshake, waits for
// the cache's done pulse (or a timeout), and returns a single-cycle cacop_data_ok.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   cacop_req/code/addr          request from WB (code[2:0] target, code[4:3] op type)
//   cacop_data_ok                one-cycle completion pulse to WB
//   ic_op_*                      icache op channel (valid/ready/type/addr/done)
//   dc_op_*                      dcache op channel (valid/ready/type/addr/done)
//   dc_idle                      dcache has nothing outstanding
//   busy                         sequencer not idle
//   op_timeout                   one-cycle pulse when WAIT is force-terminated
module cacop_sched #(
  parameter int unsigned        TMO_W   = 8,
  parameter logic [TMO_W-1:0]   TMO_MAX = 8'hFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cacop_req,
  input  logic [4:0]  cacop_code,
  input  logic [31:0] cacop_addr,
  output logic        cacop_data_ok,
  output logic        ic_op_valid,
  input  logic        ic_op_ready,
  output logic [1:0]  ic_op_type,
  output logic [31:0] ic_op_addr,
  input  logic        ic_op_done,
  output logic        dc_op_valid,
  input  logic        dc_op_ready,
  output logic [1:0]  dc_op_type,
  output logic [31:0] dc_op_addr,
  input  logic        dc_op_done,
  input  logic        dc_idle,
  output logic        busy,
  output logic        op_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         tgt_q, tgt_d;
  logic [1:0]         typ_q, typ_d;
  logic [31:0]        addr_q, addr_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;

  logic               sel_ready;
  logic               sel_done;
  logic               cnt_at_max;

  // Only targets 0 and 1 ever reach ISSUE/WAIT, so a plain 0-vs-other select is enough.
  assign sel_ready  = (tgt_q == 3'd0) ? ic_op_ready : dc_op_ready;
  assign sel_done   = (tgt_q == 3'd0) ? ic_op_done  : dc_op_done;
  assign cnt_at_max = (cnt_q == TMO_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      tgt_q   <= 3'd0;
      typ_q   <= 2'd0;
      addr_q  <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      typ_q   <= typ_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    typ_d   = typ_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cacop_req) begin
          tgt_d  = cacop_code[2:0];
          typ_d  = cacop_code[4:3];
          addr_d = cacop_addr;
          // Reserved targets and the reserved op type complete without touching a cache.
          if (cacop_code[4:3] == 2'd3 || cacop_code[2:1] != 2'd0) begin
            state_d = S_DONE;
          end else if (cacop_code[0]) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (dc_idle) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // done is not sampled here: a done in the acceptance cycle is ignored.
        if (sel_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (sel_done || cnt_at_max) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!cacop_req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign cacop_data_ok = (state_q == S_DONE);
  assign ic_op_valid   = (state_q == S_ISSUE) && (tgt_q == 3'd0);
  assign dc_op_valid   = (state_q == S_ISSUE) && (tgt_q == 3'd1);
  // A done arriving on the last counted cycle takes priority over the timeout.
  assign op_timeout    = (state_q == S_WAIT) && cnt_at_max && !sel_done;

  assign ic_op_type = typ_q;
  assign ic_op_addr = addr_q;
  assign dc_op_type = typ_q;
  assign dc_op_addr = addr_q;

endmodule

// File: tb/tb_cacop_sched.sv
// tb/tb_cacop_sched.sv - self-checking bench for cacop_sched
module tb_cacop_sched;

  localparam logic [7:0] TMO = 8'h0F;
  localparam int         TMOI = 15;

  logic        clk;
  logic        resetn;
  logic        cacop_req;
  logic [4:0]  cacop_code;
  logic [31:0] cacop_addr;
  logic        cacop_data_ok;
  logic        ic_op_valid, ic_op_ready, ic_op_done;
  logic [1:0]  ic_op_type;
  logic [31:0] ic_op_addr;
  logic        dc_op_valid, dc_op_ready, dc_op_done;
  logic [1:0]  dc_op_type;
  logic [31:0] dc_op_addr;
  logic        dc_idle;
  logic        busy;
  logic        op_timeout;

  int n_chk;
  int n_fail;

  cacop_sched #(.TMO_W(8), .TMO_MAX(TMO)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cacop_req     (cacop_req),
    .cacop_code    (cacop_code),
    .cacop_addr    (cacop_addr),
    .cacop_data_ok (cacop_data_ok),
    .ic_op_valid   (ic_op_valid),
    .ic_op_ready   (ic_op_ready),
    .ic_op_type    (ic_op_type),
    .ic_op_addr    (ic_op_addr),
    .ic_op_done    (ic_op_done),
    .dc_op_valid   (dc_op_valid),
    .dc_op_ready   (dc_op_ready),
    .dc_op_type    (dc_op_type),
    .dc_op_addr    (dc_op_addr),
    .dc_op_done    (dc_op_done),
    .dc_idle       (dc_idle),
    .busy          (busy),
    .op_timeout    (op_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] addr;
    int          rd;     // cycles the selected ready stays low while valid is up
    int          di;     // cycles dc_idle stays low after the request
    int          dd;     // WAIT-cycle index on which the cache pulses done
    int          hold;   // extra cycles WB keeps req high after data_ok
    bit          dhs;    // also pulse done in the handshake cycle (must be ignored)
    int          exp_d;  // cycle (req rise = 0) on which data_ok is expected
    bit          exp_to; // whether the op ends by timeout
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Transaction-level timing from the request cycle: no-ops finish next cycle; otherwise
  // issue starts at 1 (icache) or after the drain, the handshake is rd cycles later, and
  // WAIT lasts until done or until TMO_MAX+1 cycles have elapsed.
  function automatic void model(input logic [4:0] code, input int rd, input int di,
                                input int dd, output int d, output bit to);
    int is, w0;
    if (code[4:3] == 2'd3 || code[2:0] > 3'd1) begin
      d = 1; to = 1'b0;
    end else begin
      is = (code[2:0] == 3'd0) ? 1 : 2 + di;
      w0 = is + rd + 1;
      if (dd <= TMOI) begin d = w0 + dd + 1; to = 1'b0; end
      else            begin d = w0 + TMOI + 1; to = 1'b1; end
    end
  endfunction

  task automatic run_op(input vec_t v, input string nm);
    logic [2:0] tgt;
    logic [1:0] typ;
    bit         noop;
    int         is, hs, last;
    bit         sel_done;
    tgt  = v.code[2:0];
    typ  = v.code[4:3];
    noop = (typ == 2'd3) || (tgt > 3'd1);
    is   = (tgt == 3'd0) ? 1 : 2 + v.di;
    hs   = is + v.rd;
    last = v.exp_d + 2 + v.hold;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      cacop_req  = (c <= v.exp_d + v.hold);
      cacop_code = (c == 0) ? v.code : 5'($urandom);
      cacop_addr = (c == 0) ? v.addr : $urandom;
      sel_done   = (c == hs + 1 + v.dd) || (v.dhs && c == hs);
      dc_idle     = (!noop && tgt == 3'd1) ? (c > v.di) : 1'($urandom);
      ic_op_ready = (!noop && tgt == 3'd0) ? (c >= hs) : 1'($urandom);
      dc_op_ready = (!noop && tgt == 3'd1) ? (c >= hs) : 1'($urandom);
      ic_op_done  = (!noop && tgt == 3'd0) ? sel_done : 1'($urandom);
      dc_op_done  = (!noop && tgt == 3'd1) ? sel_done : 1'($urandom);
      #1;
      chk($sformatf("%s c%0d ic_valid", nm, c), 32'(ic_op_valid),
          32'(!noop && tgt == 3'd0 && c >= is && c <= hs));
      chk($sformatf("%s c%0d dc_valid", nm, c), 32'(dc_op_valid),
          32'(!noop && tgt == 3'd1 && c >= is && c <= hs));
      chk($sformatf("%s c%0d data_ok", nm, c), 32'(cacop_data_ok), 32'(c == v.exp_d));
      chk($sformatf("%s c%0d timeout", nm, c), 32'(op_timeout),
          32'(v.exp_to && c == v.exp_d - 1));
      chk($sformatf("%s c%0d busy", nm, c), 32'(busy),
          32'(c >= 1 && c <= v.exp_d + 1 + v.hold));
      if (c >= 1) begin
        chk($sformatf("%s c%0d ic_addr", nm, c), ic_op_addr, v.addr);
        chk($sformatf("%s c%0d dc_addr", nm, c), dc_op_addr, v.addr);
        chk($sformatf("%s c%0d ic_type", nm, c), 32'(ic_op_type), 32'(typ));
        chk($sformatf("%s c%0d dc_type", nm, c), 32'(dc_op_type), 32'(typ));
      end
    end
  endtask

  initial begin
    vec_t r;
    n_chk  = 0;
    n_fail = 0;
    resetn = 1'b0;
    cacop_req = 1'b0; cacop_code = 5'd0; cacop_addr = 32'd0;
    ic_op_ready = 1'b0; ic_op_done = 1'b0;
    dc_op_ready = 1'b0; dc_op_done = 1'b0; dc_idle = 1'b0;

    //                code      addr          rd di dd ho dhs D   to
    tbl[0] = '{5'b01000, 32'h1C000100, 0, 0, 2,  0, 0, 5,  0};
    tbl[1] = '{5'b10001, 32'h00001230, 0, 5, 0,  0, 0, 9,  0};
    tbl[2] = '{5'b00000, 32'h1C0000F0, 6, 0, 1,  1, 0, 10, 0};
    tbl[3] = '{5'b00010, 32'h12345678, 0, 0, 0,  0, 0, 1,  0};
    tbl[4] = '{5'b11000, 32'h0BADF00D, 0, 0, 0,  0, 0, 1,  0};
    tbl[5] = '{5'b11001, 32'h0000BEEF, 0, 3, 0,  1, 0, 1,  0};
    tbl[6] = '{5'b10000, 32'h00000040, 0, 0, 15, 0, 0, 18, 0};
    tbl[7] = '{5'b10000, 32'h00000080, 0, 0, 16, 0, 0, 18, 1};
    tbl[8] = '{5'b01001, 32'h00000100, 2, 0, 31, 2, 0, 21, 1};
    tbl[9] = '{5'b00000, 32'h0000FFFC, 1, 0, 3,  0, 1, 7,  0};

    repeat (2) @(negedge clk);
    chk("reset busy",     32'(busy),          32'd0);
    chk("reset data_ok",  32'(cacop_data_ok), 32'd0);
    chk("reset ic_valid", 32'(ic_op_valid),   32'd0);
    chk("reset dc_valid", 32'(dc_op_valid),   32'd0);
    chk("reset ic_addr",  ic_op_addr,         32'd0);
    chk("reset dc_type",  32'(dc_op_type),    32'd0);
    chk("reset timeout",  32'(op_timeout),    32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of WAIT, then a fresh op.
    @(negedge clk);
    cacop_req = 1'b1; cacop_code = 5'b01000; cacop_addr = 32'hA5A50000;
    ic_op_ready = 1'b1; ic_op_done = 1'b0; dc_op_ready = 1'b0; dc_op_done = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre-reset busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("async reset busy",     32'(busy),          32'd0);
    chk("async reset ic_valid", 32'(ic_op_valid),   32'd0);
    chk("async reset data_ok",  32'(cacop_data_ok), 32'd0);
    chk("async reset ic_addr",  ic_op_addr,         32'd0);
    chk("async reset ic_type",  32'(ic_op_type),    32'd0);
    cacop_req = 1'b0;
    @(negedge clk);
    #1;
    chk("in reset data_ok", 32'(cacop_data_ok), 32'd0);
    resetn = 1'b1;
    run_op(tbl[0], "post-reset");

    // Randomised ops checked against the timing model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] t;
      case ($urandom_range(0, 3))
        0: t = 3'd0;
        1: t = 3'd1;
        2: t = 3'd2;
        default: t = 3'd5;
      endcase
      r.code = {2'($urandom_range(0, 3)), t};
      r.addr = $urandom;
      r.rd   = $urandom_range(0, 3);
      r.di   = $urandom_range(0, 3);
      r.dd   = $urandom_range(0, 20);
      r.hold = $urandom_range(0, 2);
      r.dhs  = 1'($urandom);
      model(r.code, r.rd, r.di, r.dd, r.exp_d, r.exp_to);
      run_op(r, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
